// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with first-word-fall-through read, arbitrary depth, occupancy count and registered flags.
// Define SYNC_FIFO_ERR_EN to add sticky o_overflow/o_underflow outputs.
module sync_fifo_fwft #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_wen,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_ren,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_afull,
    output logic                         o_aempty,
`ifdef SYNC_FIFO_ERR_EN
    output logic                         o_overflow,
    output logic                         o_underflow,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [LW-1:0] FULL_L   = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LEVEL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LEVEL);

    // Pointers wrap at DEPTH-1 explicitly so any depth works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic             wr_acc, rd_acc, mem_we;

    // Acceptance uses only registered flags, so no input reaches an output combinationally.
    assign wr_acc = i_wen && !full_q;
    assign rd_acc = i_ren && !empty_q;
    assign mem_we = wr_acc && i_rst_n && !i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;
        if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Prefetch the next head; bypass the incoming word when it lands on the head slot.
        if (level_d != '0) begin
            if (wr_acc && (wr_ptr_q == rd_ptr_d)) rdata_d = i_wdata;
            else                                  rdata_d = mem[rd_ptr_d];
        end
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            rdata_d  = rdata_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[wr_ptr_q] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= (AFULL_L == '0);
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
            full_q   <= (level_d == FULL_L);
            empty_q  <= (level_d == '0);
            afull_q  <= (level_d >= AFULL_L);
            aempty_q <= (level_d <= AEMPTY_L);
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (i_wen && full_q);
        udf_d = udf_q | (i_ren && empty_q);
        if (i_flush) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;
`endif

    assign o_rdata  = rdata_q;
    assign o_full   = full_q;
    assign o_empty  = empty_q;
    assign o_afull  = afull_q;
    assign o_aempty = aempty_q;
    assign o_level  = level_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Randomised and directed bench for sync_fifo_fwft against a queue-based reference model.
// Exercises overflow/underflow outputs as well when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo_fwft;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 12;
    localparam int AFULL  = 10;
    localparam int AEMPTY = 2;
    localparam int LW     = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n, flush, wen, ren;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             full, empty, afull, aempty;
    logic [LW-1:0]    level;
`ifdef SYNC_FIFO_ERR_EN
    logic             ovf, udf;
`endif

    sync_fifo_fwft #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPTY)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_wen(wen), .i_wdata(wdata),
        .i_ren(ren), .o_rdata(rdata), .o_full(full), .o_empty(empty), .o_afull(afull),
        .o_aempty(aempty),
`ifdef SYNC_FIFO_ERR_EN
        .o_overflow(ovf), .o_underflow(udf),
`endif
        .o_level(level)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue, sticky error bits, reset marker.
    logic [WIDTH-1:0] mq[$];
    bit               m_ovf, m_udf, m_rst;
    int               n_total = 0;
    int               n_pass  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        check_eq({tag, "_level"},  32'(level),  32'(sz));
        check_eq({tag, "_empty"},  32'(empty),  32'(sz == 0));
        check_eq({tag, "_full"},   32'(full),   32'(sz == DEPTH));
        check_eq({tag, "_afull"},  32'(afull),  32'(sz >= AFULL));
        check_eq({tag, "_aempty"}, 32'(aempty), 32'(sz <= AEMPTY));
        if (sz > 0)     check_eq({tag, "_rdata"}, rdata, mq[0]);
        else if (m_rst) check_eq({tag, "_rdata_rst"}, rdata, 32'h0);
`ifdef SYNC_FIFO_ERR_EN
        check_eq({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        check_eq({tag, "_udf"}, 32'(udf), 32'(m_udf));
`endif
    endtask

    // Drive one cycle, advance the model at the edge, then check outputs 1 ns later.
    task automatic step(input string tag, input logic w, input logic [WIDTH-1:0] d,
                        input logic r, input logic fl, input logic rn);
        bit wa, ra;
        rst_n = rn; flush = fl; wen = w; wdata = d; ren = r;
        @(posedge clk);
        if (!rn) begin
            mq.delete(); m_ovf = 0; m_udf = 0; m_rst = 1;
        end else if (fl) begin
            mq.delete(); m_ovf = 0; m_udf = 0;
        end else begin
            wa = w && (mq.size() < DEPTH);
            ra = r && (mq.size() > 0);
            if (w && !wa) m_ovf = 1;
            if (r && !ra) m_udf = 1;
            if (ra) void'(mq.pop_front());
            if (wa) mq.push_back(d);
            if (wa || ra) m_rst = 0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int pw, pr;
        rst_n = 0; flush = 0; wen = 0; ren = 0; wdata = '0;

        // Reset with junk on the request inputs
        step("rst0", 1, 32'hDEAD_BEEF, 1, 0, 0);
        step("rst1", 0, 0, 0, 0, 0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_empty", 32'(empty), 32'd1);

        // Single write then read
        step("w1", 1, 32'hA5A5_0001, 0, 0, 1);
        check_eq("w1_rdata_const", rdata, 32'hA5A5_0001);
        check_eq("w1_level_const", 32'(level), 32'd1);
        step("r1", 0, 0, 1, 0, 1);
        check_eq("r1_empty_const", 32'(empty), 32'd1);

        // Overfill with words 1..DEPTH+2 (pointers start offset by one, so drain wraps)
        for (int i = 1; i <= DEPTH + 2; i++) step("fill", 1, 32'(i), 0, 0, 1);
        check_eq("ovf_full_const", 32'(full), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            check_eq("drain_order", rdata, 32'(i));
            step("drain", 0, 0, 1, 0, 1);
        end
        step("udf", 0, 0, 1, 0, 1);

        // Full with simultaneous read+write, then empty with simultaneous read+write
        for (int i = 0; i < DEPTH; i++) step("fill2", 1, 32'h100 + 32'(i), 0, 0, 1);
        step("full_rw", 1, 32'hBAD0_0000, 1, 0, 1);
        check_eq("full_rw_level", 32'(level), 32'(DEPTH - 1));
        check_eq("full_rw_head", rdata, 32'h101);
        step("flush0", 0, 0, 0, 1, 1);
        step("empty_rw", 1, 32'h5555_AAAA, 1, 0, 1);
        check_eq("empty_rw_rdata", rdata, 32'h5555_AAAA);
        step("lvl1_rw", 1, 32'h6666_0000, 1, 0, 1);
        check_eq("lvl1_rw_rdata", rdata, 32'h6666_0000);
        step("flush1", 0, 0, 0, 1, 1);

        // Fill one at a time; flags checked against level every step
        for (int i = 0; i < DEPTH; i++) step("flags", 1, $urandom, 0, 0, 1);

        // Flush with a concurrent write at 9 entries
        step("flush2", 0, 0, 0, 1, 1);
        for (int i = 0; i < 9; i++) step("nine", 1, 32'h900 + 32'(i), 0, 0, 1);
        step("flush_w", 1, 32'hFFFF_FFFF, 0, 1, 1);
        check_eq("flush_level_const", 32'(level), 32'd0);
        step("post_flush_w", 1, 32'h1234_5678, 0, 0, 1);
        check_eq("post_flush_rdata", rdata, 32'h1234_5678);

        // Random traffic with phase-varying bias, occasional flushes and resets
        pw = 50; pr = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 256 == 0) begin
                pw = $urandom_range(90, 10);
                pr = $urandom_range(90, 10);
            end
            step("rand", $urandom_range(99) < pw, $urandom, $urandom_range(99) < pr,
                 $urandom_range(299) == 0, !($urandom_range(999) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
